div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of divisor and cycle counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 10, divisor value after reset (legal range 1..2^WIDTH-1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  configuration accepted this cycle if cfg_valid.
REQ-007 SHALL have port cfg_div  input  WIDTH  requested divisor (tick period in clk cycles).
REQ-008 SHALL have port cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic mode.
REQ-009 SHALL have port start  input  1  begin counting.
REQ-010 SHALL have port stop  input  1  abort counting.
REQ-011 SHALL have port pause  input  1  freeze counter while high.
REQ-012 SHALL have port tick  output  1  one-cycle pulse at end of each period.
REQ-013 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-014 SHALL have port tick_cnt  output  16  ticks emitted since last start.
REQ-015 SHALL have port err  output  1  sticky: zero divisor rejected.
REQ-016 SHALL have ports irq  output  1  and irq_clr  input  1  (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HOLD; busy = (state != IDLE).
REQ-018 SHALL drive cfg_ready = 1 only in IDLE; transfer = cfg_valid && cfg_ready.
REQ-019 SHALL, on transfer with cfg_div != 0, load div_reg <= cfg_div, mode_reg <= cfg_oneshot, clear err.
REQ-020 SHALL, on transfer with cfg_div == 0, leave div_reg/mode_reg unchanged and set err.
REQ-021 SHALL ignore cfg_valid outside IDLE (no load, no err change).
REQ-022 SHALL, in IDLE with start=1 and stop=0, enter RUN, set cnt <= 0, clear tick_cnt; start has priority over a same-cycle transfer (the configuration still loads, counting uses the previous div_reg).
REQ-023 SHALL, in RUN, increment cnt each cycle; at cnt == div_reg-1 assert tick (combinational decode of state and cnt) and set cnt <= 0.
REQ-024 SHALL produce the first tick in the div_reg-th cycle of RUN, then every div_reg cycles; div_reg = 1 gives tick every RUN cycle.
REQ-025 SHALL increment tick_cnt on every tick, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL, in one-shot mode, return to IDLE on the cycle after the first tick, cnt <= 0.
REQ-027 SHALL, in RUN with pause=1, enter HOLD with cnt frozen and no tick; HOLD with pause=0 returns to RUN and resumes from the frozen cnt.
REQ-028 SHALL, on stop=1 in RUN or HOLD, enter IDLE, cnt <= 0, no tick that cycle; tick_cnt retained.
REQ-029 SHALL apply priority stop > pause > count; start while busy is ignored.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state=IDLE, cnt=0, div_reg=DEFAULT_DIV, mode_reg=0, tick_cnt=0, err=0, irq=0.
REQ-031 SHALL hold outputs during reset at tick=0, busy=0, cfg_ready=1; reset mid-RUN aborts with no tick.

Configuration
REQ-032 SHALL use macro DIV_CTRL_IRQ_EN to compile the interrupt feature in or out.
REQ-033 SHALL, with DIV_CTRL_IRQ_EN defined, set irq sticky on every tick, clear it on irq_clr=1, set winning over same-cycle clear.
REQ-034 SHALL, without DIV_CTRL_IRQ_EN, tie irq to 0, ignore irq_clr, and keep the port list unchanged.

Verification
REQ-035 SHALL cover: cfg_div=4 periodic, start, run 20 cycles -> tick in RUN cycles 4, 8, 12, 16, 20; tick_cnt=5.
REQ-036 SHALL cover: cfg_div=3 one-shot, start -> single tick in RUN cycle 3, busy low the next cycle, tick_cnt=1.
REQ-037 SHALL cover: cfg_div=0 -> err=1, div_reg unchanged (DEFAULT_DIV tick period 10); then cfg_div=2 -> err=0.
REQ-038 SHALL cover: cfg_div=5, pause for 3 cycles after RUN cycle 2 -> first tick delayed to cycle 8; stop with pause=1 in same cycle -> IDLE.
REQ-039 SHALL cover: cfg_div=1, run 65537 ticks -> tick_cnt wraps to 0x0001; rst_n low mid-RUN -> all reset values, no tick.
REQ-040 SHALL cover: with DIV_CTRL_IRQ_EN, tick and irq_clr in the same cycle -> irq=1; without it -> irq stays 0 throughout.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: programmable tick divider with IDLE/RUN/HOLD control and a sticky zero-divisor error.
// Define DIV_CTRL_IRQ_EN to build in the sticky tick interrupt (irq/irq_clr).
module div_ctrl #(
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic             tick,
    output logic             busy,
    output logic [15:0]      tick_cnt,
    output logic             err,
    output logic             irq,
    input  logic             irq_clr
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_reg;
    logic             mode_reg;
    // A run snapshots the divisor/mode at start, so a same-cycle config load only affects later runs.
    logic [WIDTH-1:0] run_div;
    logic             run_mode;
    logic             xfer;
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign tick      = (state == RUN) && !stop && !pause && (cnt == run_div - WIDTH'(1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_reg  <= WIDTH'(DEFAULT_DIV);
            mode_reg <= 1'b0;
            run_div  <= WIDTH'(DEFAULT_DIV);
            run_mode <= 1'b0;
            tick_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (xfer) begin
                if (cfg_div != '0) begin
                    div_reg  <= cfg_div;
                    mode_reg <= cfg_oneshot;
                    err      <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                IDLE: if (start && !stop) begin
                    state    <= RUN;
                    cnt      <= '0;
                    tick_cnt <= '0;
                    run_div  <= div_reg;
                    run_mode <= mode_reg;
                end
                RUN: if (stop) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (pause) begin
                    state <= HOLD;
                end else if (tick) begin
                    cnt      <= '0;
                    tick_cnt <= tick_cnt + 16'd1;
                    if (run_mode) state <= IDLE;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
                HOLD: if (stop) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (!pause) begin
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DIV_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= tick ? 1'b1 : (irq_clr ? 1'b0 : irq);
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against a behavioural period model.
module tb_div_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_valid = 0, cfg_oneshot = 0, start = 0, stop = 0, pause = 0, irq_clr = 0;
    logic [31:0] cfg_div = '0;
    logic        cfg_ready, tick, busy, err, irq;
    logic [15:0] tick_cnt;
    int tests = 0, fails = 0;

    div_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
        .pause(pause), .tick(tick), .busy(busy), .tick_cnt(tick_cnt), .err(err),
        .irq(irq), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    // Model: a run is a sequence of periods of pdiv counted cycles; pause/hold cycles do not count.
    bit          m_running, m_held, m_mode, m_pmode, m_err, m_irq;
    int unsigned m_div, m_pdiv, m_pos, m_tcnt;
    logic        obs_tick, obs_busy, obs_ready, exp_tick, exp_busy, exp_ready;

    function automatic void m_reset();
        m_running = 0; m_held = 0; m_pos = 0; m_div = 10; m_pdiv = 10;
        m_mode = 0; m_pmode = 0; m_tcnt = 0; m_err = 0; m_irq = 0;
    endfunction

    task automatic step();
        bit was_idle;
        #1;
        obs_tick = tick; obs_busy = busy; obs_ready = cfg_ready;
        exp_ready = !m_running;
        exp_busy  = m_running;
        exp_tick  = m_running && !m_held && !stop && !pause && (m_pos + 1 == m_pdiv);
        was_idle  = !m_running;
        if (was_idle && start && !stop) begin
            m_pdiv = m_div; m_pmode = m_mode; m_running = 1; m_held = 0; m_pos = 0; m_tcnt = 0;
        end else if (m_running) begin
            if (stop) begin
                m_running = 0; m_held = 0; m_pos = 0;
            end else if (pause) begin
                m_held = 1;
            end else if (m_held) begin
                m_held = 0;
            end else if (exp_tick) begin
                m_tcnt = (m_tcnt + 1) % 65536;
                m_pos  = 0;
                if (m_pmode) m_running = 0;
            end else begin
                m_pos++;
            end
        end
        if (was_idle && cfg_valid) begin
            if (cfg_div != 0) begin m_div = cfg_div; m_mode = cfg_oneshot; m_err = 0; end
            else m_err = 1;
        end
`ifdef DIV_CTRL_IRQ_EN
        if (exp_tick) m_irq = 1;
        else if (irq_clr) m_irq = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int unsigned d, input bit os);
        cfg_valid = 1; cfg_div = d; cfg_oneshot = os;
        step();
        cfg_valid = 0;
    endtask

    task automatic go();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic hw_reset();
        rst_n = 0; cfg_valid = 0; start = 0; stop = 0; pause = 0; irq_clr = 0;
        m_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        tests++;
        if (tick !== 0 || busy !== 0 || cfg_ready !== 1 || tick_cnt !== 0 || err !== 0 || irq !== 0) begin
            fails++;
            $display("FAIL reset: tick=%b busy=%b ready=%b tcnt=%0d err=%b irq=%b, need 0 0 1 0 0 0",
                     tick, busy, cfg_ready, tick_cnt, err, irq);
        end
        hw_reset();
    endtask

    task automatic test_periodic();
        configure(4, 0);
        go();
        for (int i = 1; i <= 20; i++) begin
            step();
            tests++;
            if (obs_tick !== ((i % 4) == 0)) begin
                fails++; $display("FAIL periodic_tick cyc%0d: got %b need %b", i, obs_tick, (i % 4) == 0);
            end
        end
        tests++;
        if (tick_cnt !== 16'd5) begin fails++; $display("FAIL periodic_tcnt: got %0d need 5", tick_cnt); end
        stop = 1; step(); stop = 0;
        tests++;
        if (busy !== 0 || tick_cnt !== 16'd5) begin
            fails++; $display("FAIL periodic_stop: busy=%b tcnt=%0d need 0 5", busy, tick_cnt);
        end
    endtask

    task automatic test_oneshot();
        configure(3, 1);
        go();
        for (int i = 1; i <= 3; i++) begin
            step();
            tests++;
            if (obs_tick !== (i == 3) || obs_busy !== 1) begin
                fails++; $display("FAIL oneshot cyc%0d: tick=%b busy=%b need %b 1", i, obs_tick, obs_busy, i == 3);
            end
        end
        tests++;
        if (busy !== 0 || tick_cnt !== 16'd1) begin
            fails++; $display("FAIL oneshot_end: busy=%b tcnt=%0d need 0 1", busy, tick_cnt);
        end
    endtask

    task automatic test_err();
        hw_reset();
        configure(0, 1);
        tests++;
        if (err !== 1) begin fails++; $display("FAIL err_set: got %b need 1", err); end
        go();
        for (int i = 1; i <= 20; i++) begin
            step();
            tests++;
            if (obs_tick !== ((i % 10) == 0)) begin
                fails++; $display("FAIL err_default_div cyc%0d: got %b need %b", i, obs_tick, (i % 10) == 0);
            end
        end
        cfg_valid = 1; cfg_div = 3; stop = 1; step(); stop = 0;
        tests++;
        if (err !== 1) begin fails++; $display("FAIL err_busy_ignore: got %b need 1", err); end
        configure(2, 0);
        tests++;
        if (err !== 0) begin fails++; $display("FAIL err_clear: got %b need 0", err); end
    endtask

    task automatic test_pause_stop();
        configure(5, 0);
        go();
        for (int i = 1; i <= 8; i++) begin
            pause = (i == 3 || i == 4);
            step();
            tests++;
            if (obs_tick !== (i == 8) || obs_tick !== exp_tick) begin
                fails++; $display("FAIL pause_tick cyc%0d: got %b need %b", i, obs_tick, i == 8);
            end
        end
        pause = 1; stop = 1; step(); pause = 0; stop = 0;
        tests++;
        if (obs_tick !== 0 || busy !== 0 || tick_cnt !== 16'd1) begin
            fails++; $display("FAIL pause_stop: tick=%b busy=%b tcnt=%0d need 0 0 1", obs_tick, busy, tick_cnt);
        end
    endtask

    task automatic test_start_xfer();
        configure(3, 0);
        cfg_valid = 1; cfg_div = 6; cfg_oneshot = 0; start = 1;
        step();
        cfg_valid = 0; start = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if (obs_tick !== ((i % 3) == 0)) begin
                fails++; $display("FAIL start_xfer_old cyc%0d: got %b need %b", i, obs_tick, (i % 3) == 0);
            end
        end
        stop = 1; step(); stop = 0;
        go();
        for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
            if (obs_tick !== (i == 6)) begin
                fails++; $display("FAIL start_xfer_new cyc%0d: got %b need %b", i, obs_tick, i == 6);
            end
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_wrap_and_reset();
        int n = 0;
        configure(1, 0);
        go();
        for (int i = 0; i < 65537; i++) begin
            step();
            n += int'(obs_tick);
        end
        tests++;
        if (n != 65537 || tick_cnt !== 16'h0001) begin
            fails++; $display("FAIL wrap: ticks=%0d tcnt=%h need 65537 0001", n, tick_cnt);
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (tick !== 0 || busy !== 0 || cfg_ready !== 1 || tick_cnt !== 0 || err !== 0 || irq !== 0) begin
            fails++;
            $display("FAIL reset_mid_run: tick=%b busy=%b ready=%b tcnt=%0d err=%b irq=%b, need 0 0 1 0 0 0",
                     tick, busy, cfg_ready, tick_cnt, err, irq);
        end
        hw_reset();
        go();
        for (int i = 1; i <= 10; i++) begin
            step();
            tests++;
            if (obs_tick !== (i == 10)) begin
                fails++; $display("FAIL reset_div cyc%0d: got %b need %b", i, obs_tick, i == 10);
            end
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_irq();
        configure(2, 0);
        go();
        irq_clr = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            tests++;
`ifdef DIV_CTRL_IRQ_EN
            if (irq !== ((i % 2) == 0)) begin
                fails++; $display("FAIL irq cyc%0d: got %b need %b", i, irq, (i % 2) == 0);
            end
`else
            if (irq !== 0) begin fails++; $display("FAIL irq_off cyc%0d: got %b need 0", i, irq); end
`endif
        end
        irq_clr = 0; stop = 1; step(); stop = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_div     = $urandom_range(0, 6);
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 19) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            irq_clr     = ($urandom_range(0, 2) == 0);
            step();
            tests++;
            if (obs_tick !== exp_tick || obs_busy !== exp_busy || obs_ready !== exp_ready ||
                tick_cnt !== 16'(m_tcnt) || err !== m_err || irq !== m_irq) begin
                fails++;
                $display("FAIL random cyc%0d: tick/busy/ready/tcnt/err/irq=%b%b%b/%0d/%b%b need %b%b%b/%0d/%b%b",
                         i, obs_tick, obs_busy, obs_ready, tick_cnt, err, irq,
                         exp_tick, exp_busy, exp_ready, m_tcnt, m_err, m_irq);
            end
        end
        cfg_valid = 0; start = 0; stop = 0; pause = 0; irq_clr = 0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_err();
        test_pause_stop();
        test_start_xfer();
        test_irq();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
